// File: rtl/gpi.sv
// GPI: debounced general-purpose input pins with per-pin edge-pending flags,
// a registered level interrupt and a zero-wait-state memory-mapped register port.
module gpi #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] gpi_i,
   input  logic             select_i,
   output logic             mem_ready_o,
   input  logic [3:0]       mem_wstrb_i,
   input  logic [31:0]      mem_addr_i,
   input  logic [31:0]      mem_wdata_i,
   output logic [31:0]      mem_rdata_o,
   output logic             irq_o
);

   typedef enum logic [3:0] {
      REG_PIN     = 4'd0,
      REG_PEND    = 4'd1,
      REG_RISE_EN = 4'd2,
      REG_FALL_EN = 4'd3,
      REG_IRQ_EN  = 4'd4
   } reg_e;

   localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] stb_q, stb_d, stb_dly_q;
   logic [15:0]      cnt_q [WIDTH];
   logic [15:0]      cnt_d [WIDTH];
   logic [WIDTH-1:0] pend_q, pend_d, pend_clr;
   logic [WIDTH-1:0] rise_en_q, fall_en_q, irq_en_q;
   logic [WIDTH-1:0] rise, fall, wdata;
   logic             irq_q, irq_d;
   logic             wr_en;
   reg_e             reg_sel;
   logic [31:0]      rdata_sel;
   logic             unused_bits;

   assign reg_sel     = reg_e'(mem_addr_i[5:2]);
   assign wr_en       = select_i & (|mem_wstrb_i);
   assign wdata       = mem_wdata_i[WIDTH-1:0];
   assign unused_bits = ^{mem_addr_i[31:6], mem_addr_i[1:0], mem_wdata_i};

   // Debounce: a pin must disagree with stb for DB_CYCLES consecutive cycles.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      stb_d = stb_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stb_q[i]) begin
            if (cnt_q[i] == DB_LAST) stb_d[i] = sync2_q[i];
            else                     cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   assign rise     = stb_q & ~stb_dly_q;
   assign fall     = ~stb_q & stb_dly_q;
   assign pend_clr = (wr_en && reg_sel == REG_PEND) ? wdata : '0;
   // New edges are OR-ed in after the clear so a simultaneous set wins.
   assign pend_d   = (pend_q & ~pend_clr) | (rise & rise_en_q) | (fall & fall_en_q);
   assign irq_d    = |(pend_q & irq_en_q);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stb_q     <= '0;
         stb_dly_q <= '0;
         pend_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync1_q   <= gpi_i;
         sync2_q   <= sync1_q;
         stb_q     <= stb_d;
         stb_dly_q <= stb_q;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
      end
   end

   // NOTE: the counter array is reset explicitly so a reset mid-debounce discards partial counts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         irq_en_q  <= '0;
      end else if (wr_en) begin
         if (reg_sel == REG_RISE_EN) rise_en_q <= wdata;
         if (reg_sel == REG_FALL_EN) fall_en_q <= wdata;
         if (reg_sel == REG_IRQ_EN)  irq_en_q  <= wdata;
      end
   end

   always_comb begin
      rdata_sel = '0;
      case (reg_sel)
         REG_PIN:     rdata_sel[WIDTH-1:0] = stb_q;
         REG_PEND:    rdata_sel[WIDTH-1:0] = pend_q;
         REG_RISE_EN: rdata_sel[WIDTH-1:0] = rise_en_q;
         REG_FALL_EN: rdata_sel[WIDTH-1:0] = fall_en_q;
         REG_IRQ_EN:  rdata_sel[WIDTH-1:0] = irq_en_q;
         default:     rdata_sel = '0;
      endcase
   end

   assign mem_ready_o = select_i;
   assign mem_rdata_o = select_i ? rdata_sel : 32'd0;
   assign irq_o       = irq_q;

endmodule
